sigen_wb_ctrl: RTL and testbench
================================

Name: sigen_wb_ctrl

Overview:
- Wishbone classic slave that sits directly upstream of signal_generator inside the user project wrapper.
- Decodes a 256-byte register window and holds the generator configuration: enable, waveform select, tuning word and amplitude.
- Buffers arbitrary-waveform samples in a small FIFO and hands them to the generator over a valid/ready stream.
- Provides sticky error flags and one interrupt line.

Parameters:
- BASE_ADDR, 32'h3000_0000, window base; bits [31:8] are compared.
- FIFO_DEPTH, 16, sample FIFO entries; must be a power of 2, at least 4.
- SAMPLE_W, 12, sample and amplitude width.

Ports:
- wb_clk_i  in  1  single clock.
- wb_rst_i  in  1  synchronous, active-high reset.
- wbs_stb_i  in  1  strobe.
- wbs_cyc_i  in  1  bus cycle.
- wbs_we_i  in  1  write enable.
- wbs_sel_i  in  4  byte selects.
- wbs_adr_i  in  32  byte address.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  acknowledge.
- wbs_dat_o  out  32  read data.
- gen_enable  out  1  generator run.
- gen_wave_sel  out  2  0 sine, 1 square, 2 triangle, 3 arbitrary (FIFO).
- gen_tuning_word  out  32  phase increment.
- gen_amplitude  out  SAMPLE_W  peak amplitude.
- gen_cfg_update  out  1  one-cycle pulse after any config write.
- smp_data  out  SAMPLE_W  FIFO head sample.
- smp_valid  out  1  FIFO not empty.
- smp_ready  in  1  generator consumes the head sample.
- irq_o  out  1  level interrupt.

Behaviour:
- Clock is wb_clk_i; reset is wb_rst_i, synchronous and active-high. Every state element is reset on the clock edge while wb_rst_i=1.
- Reset values: all outputs 0, config registers 0, FIFO empty, sticky flags 0.
- Reset during an access drops it: no ack is issued, and the master retries.
- Access: req = cyc & stb & ~ack. ack is registered, high exactly one cycle, one cycle after req, so latency is 1 cycle. ack never asserts on back-to-back cycles.
- wbs_dat_o is valid only in the ack cycle and is 0 otherwise.
- Decode uses adr[31:8] == BASE_ADDR[31:8] and word offset adr[7:2].
- Out-of-window or unmapped offsets still ack: reads return 0 and writes are ignored, so the bus never hangs.
- Register writes take effect on the ack edge.
- Register map:
  - 0x00 CTRL RW: [0] enable, [2:1] wave_sel, [3] flush (write-1, reads 0), [4] irq_en.
  - 0x04 TUNING RW, 32 bits.
  - 0x08 AMPLITUDE RW, [SAMPLE_W-1:0].
  - 0x0C STATUS: [0] empty, [1] full, [2] underrun (W1C), [3] overflow (W1C), [15:8] level.
  - 0x10 PUSH WO: [SAMPLE_W-1:0] pushed when any sel bit is set; reads 0.
  - 0x14 ID RO: 32'h5347_0001.
- wbs_sel_i masks bytes on CTRL, TUNING, AMPLITUDE and the W1C bits. A write with sel=0 is acked but has no effect.
- gen_cfg_update pulses in the ack cycle of any write to CTRL, TUNING or AMPLITUDE, even if the value is unchanged.
- FIFO pop: occurs when smp_valid & smp_ready.
- FIFO push:
  - Accepted when not full.
  - When full and a pop occurs in the same cycle, the push is accepted and the level is unchanged.
  - When full with no pop, the push is dropped and overflow is set.
- Empty plus push in the same cycle: smp_valid rises the next cycle. There is no fall-through.
- Underrun is set when smp_ready=1, FIFO empty, enable=1 and wave_sel=3.
- Flush: empties the FIFO on the ack edge and wins over a simultaneous pop. Sticky flags are not cleared by flush.
- Pointers wrap modulo FIFO_DEPTH. Level is held in log2(FIFO_DEPTH)+1 bits, zero-extended in STATUS.
- W1C versus set in the same cycle: set wins.
- irq_o is registered: irq_en & (underrun | overflow).

Decomposition:
- sigen_pkg holds:
  - register offset localparams;
  - wave_sel enum (WAVE_SINE, WAVE_SQUARE, WAVE_TRI, WAVE_ARB);
  - the SIGEN_ID constant;
  - STATUS bit positions.
- Sub-module sigen_sample_fifo: synchronous FIFO with push, pop, flush, full, empty and level outputs, parameterised by depth and width.
- The top level contains the bus decode, registers and flags.

Test Plan:
- Reset, then read ID at 0x3000_0014 -> ack exactly 1 cycle after stb, dat_o=0x5347_0001; all gen_* outputs, smp_valid and irq_o are 0.
- Write TUNING=0x0123_4567 with sel=4'b0011, then write CTRL=0x7 -> tuning becomes 0x0000_4567; enable=1, wave_sel=3; gen_cfg_update pulses once per write.
- Push 16 samples 0x001..0x010 with smp_ready=0, then one more -> STATUS full=1, level=16, overflow=1; smp_data=0x001.
- Raise smp_ready for 16 cycles -> data 0x001..0x010 pops in order. Keep smp_ready high while empty -> underrun=1; with irq_en set, irq_o=1. W1C STATUS 0xC -> flags clear and irq_o drops.
- FIFO full, push with smp_ready=1 in the same cycle -> push accepted, level stays 16, no overflow.
- Access 0x3000_0200 and offset 0x18 -> acked, read returns 0, no register changes. Assert wb_rst_i mid-access -> no ack, registers are 0 next cycle.

Source files
------------

// File: rtl/sigen_pkg.sv
// Register map, wave encodings and status layout shared by the signal generator bus slave.
// Pure declarations: no latency, no flow control.
// Word offsets are adr[7:2] inside the 256-byte window.
package sigen_pkg;

    localparam logic [5:0] OFF_CTRL      = 6'h00;
    localparam logic [5:0] OFF_TUNING    = 6'h01;
    localparam logic [5:0] OFF_AMPLITUDE = 6'h02;
    localparam logic [5:0] OFF_STATUS    = 6'h03;
    localparam logic [5:0] OFF_PUSH      = 6'h04;
    localparam logic [5:0] OFF_ID        = 6'h05;

    localparam logic [31:0] SIGEN_ID = 32'h5347_0001;

    typedef enum logic [1:0] {
        WAVE_SINE   = 2'd0,
        WAVE_SQUARE = 2'd1,
        WAVE_TRI    = 2'd2,
        WAVE_ARB    = 2'd3
    } wave_sel_t;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_FLUSH  = 3;
    localparam int CTRL_IRQ_EN = 4;

    localparam int ST_EMPTY     = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_UNDERRUN  = 2;
    localparam int ST_OVERFLOW  = 3;
    localparam int ST_LEVEL_LSB = 8;

    function automatic logic [31:0] sel_mask(input logic [3:0] sel);
        return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction

endpackage

// File: rtl/sigen_sample_fifo.sv
// Synchronous sample FIFO with flush and occupancy level.
// Latency: a push is visible at the head the cycle after it is written (no fall-through).
// Backpressure: push is dropped when full unless a pop frees a slot in the same cycle; flush wins over pop.
module sigen_sample_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 12,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    input  logic             flush,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head,
    output logic [AW:0]      level
);

    localparam logic [AW-1:0] PTR_ONE  = 1;
    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW:0]   CNT_FULL = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             pop_ok;
    logic             push_ok;

    assign empty   = (count == '0);
    assign full    = (count == CNT_FULL);
    assign level   = count;
    assign head    = mem[rd_ptr];
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + PTR_ONE;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sigen_wb_ctrl.sv
// Wishbone classic slave holding signal generator config, sample FIFO, sticky flags and irq.
// Latency: ack one cycle after request, never on consecutive cycles; config takes effect on the ack edge.
// Backpressure: bus never stalls; samples stream out on smp_valid/smp_ready, pushes into a full FIFO are dropped.
module sigen_wb_ctrl
    import sigen_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
    parameter int          FIFO_DEPTH = 16,
    parameter int          SAMPLE_W   = 12
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                wbs_stb_i,
    input  logic                wbs_cyc_i,
    input  logic                wbs_we_i,
    input  logic [3:0]          wbs_sel_i,
    input  logic [31:0]         wbs_adr_i,
    input  logic [31:0]         wbs_dat_i,
    output logic                wbs_ack_o,
    output logic [31:0]         wbs_dat_o,
    output logic                gen_enable,
    output logic [1:0]          gen_wave_sel,
    output logic [31:0]         gen_tuning_word,
    output logic [SAMPLE_W-1:0] gen_amplitude,
    output logic                gen_cfg_update,
    output logic [SAMPLE_W-1:0] smp_data,
    output logic                smp_valid,
    input  logic                smp_ready,
    output logic                irq_o
);

    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    wave_sel_t   wave_q;
    logic        irq_en;
    logic        underrun;
    logic        overflow;

    logic        req;
    logic        hit;
    logic [5:0]  off;
    logic        wr_ctrl, wr_tuning, wr_amp, wr_status, wr_push;
    logic [31:0] byte_mask;
    logic [31:0] rdata;
    logic [31:0] status;

    logic        fifo_full, fifo_empty;
    logic [LW-1:0] fifo_level;
    logic        flush, push, pop;
    logic        set_unf, set_ovf, clr_unf, clr_ovf;
    logic        unused_adr;

    assign unused_adr = ^wbs_adr_i[1:0];

    assign req       = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
    assign hit       = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign off       = wbs_adr_i[7:2];
    assign byte_mask = sel_mask(wbs_sel_i);

    assign wr_ctrl   = req & wbs_we_i & hit & (off == OFF_CTRL);
    assign wr_tuning = req & wbs_we_i & hit & (off == OFF_TUNING);
    assign wr_amp    = req & wbs_we_i & hit & (off == OFF_AMPLITUDE);
    assign wr_status = req & wbs_we_i & hit & (off == OFF_STATUS);
    assign wr_push   = req & wbs_we_i & hit & (off == OFF_PUSH);

    assign smp_valid = ~fifo_empty;
    assign pop       = smp_valid & smp_ready;
    assign flush     = wr_ctrl & wbs_sel_i[0] & wbs_dat_i[CTRL_FLUSH];
    assign push      = wr_push & (|wbs_sel_i);

    // A push into a full FIFO survives only if the head leaves in the same cycle.
    assign set_ovf = push & fifo_full & ~pop;
    assign set_unf = smp_ready & fifo_empty & gen_enable & (wave_q == WAVE_ARB);
    assign clr_unf = wr_status & wbs_sel_i[0] & wbs_dat_i[ST_UNDERRUN];
    assign clr_ovf = wr_status & wbs_sel_i[0] & wbs_dat_i[ST_OVERFLOW];

    assign gen_wave_sel = wave_q;

    always_comb begin
        status                         = '0;
        status[ST_EMPTY]               = fifo_empty;
        status[ST_FULL]                = fifo_full;
        status[ST_UNDERRUN]            = underrun;
        status[ST_OVERFLOW]            = overflow;
        status[ST_LEVEL_LSB +: LW]     = fifo_level;
    end

    always_comb begin
        rdata = '0;
        if (hit) begin
            case (off)
                OFF_CTRL: begin
                    rdata[CTRL_EN]     = gen_enable;
                    rdata[2:1]         = wave_q;
                    rdata[CTRL_IRQ_EN] = irq_en;
                end
                OFF_TUNING:    rdata = gen_tuning_word;
                OFF_AMPLITUDE: rdata[SAMPLE_W-1:0] = gen_amplitude;
                OFF_STATUS:    rdata = status;
                OFF_ID:        rdata = SIGEN_ID;
                default:       rdata = '0;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wbs_ack_o       <= 1'b0;
            wbs_dat_o       <= '0;
            gen_enable      <= 1'b0;
            wave_q          <= WAVE_SINE;
            gen_tuning_word <= '0;
            gen_amplitude   <= '0;
            gen_cfg_update  <= 1'b0;
            irq_en          <= 1'b0;
            underrun        <= 1'b0;
            overflow        <= 1'b0;
            irq_o           <= 1'b0;
        end else begin
            wbs_ack_o      <= req;
            wbs_dat_o      <= (req & ~wbs_we_i) ? rdata : '0;
            gen_cfg_update <= wr_ctrl | wr_tuning | wr_amp;

            if (wr_ctrl && wbs_sel_i[0]) begin
                gen_enable <= wbs_dat_i[CTRL_EN];
                wave_q     <= wave_sel_t'(wbs_dat_i[2:1]);
                irq_en     <= wbs_dat_i[CTRL_IRQ_EN];
            end
            if (wr_tuning) begin
                gen_tuning_word <= (gen_tuning_word & ~byte_mask) | (wbs_dat_i & byte_mask);
            end
            if (wr_amp) begin
                gen_amplitude <= (gen_amplitude & ~byte_mask[SAMPLE_W-1:0])
                               | (wbs_dat_i[SAMPLE_W-1:0] & byte_mask[SAMPLE_W-1:0]);
            end

            underrun <= set_unf | (underrun & ~clr_unf);
            overflow <= set_ovf | (overflow & ~clr_ovf);
            irq_o    <= irq_en & (underrun | overflow);
        end
    end

    sigen_sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (SAMPLE_W)
    ) u_fifo (
        .clk      (wb_clk_i),
        .rst      (wb_rst_i),
        .push     (push),
        .push_dat (wbs_dat_i[SAMPLE_W-1:0]),
        .pop      (pop),
        .flush    (flush),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .head     (smp_data),
        .level    (fifo_level)
    );

endmodule

// File: tb/tb_sigen_wb_ctrl.sv
// Randomised bench for sigen_wb_ctrl: queue-based reference model, read-data and sample scoreboards.
module tb_sigen_wb_ctrl;

    localparam logic [31:0] BASE  = 32'h3000_0000;
    localparam int          DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] adr = '0, dat = '0;
    logic        ack;
    logic [31:0] dat_o;
    logic        en;
    logic [1:0]  wave;
    logic [31:0] tun;
    logic [11:0] amp;
    logic        cfg_upd;
    logic [11:0] smp_data;
    logic        smp_valid;
    logic        smp_ready = 1'b0;
    logic        irq;

    always #5 clk = ~clk;

    sigen_wb_ctrl dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we),
        .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(dat), .wbs_ack_o(ack), .wbs_dat_o(dat_o),
        .gen_enable(en), .gen_wave_sel(wave), .gen_tuning_word(tun), .gen_amplitude(amp),
        .gen_cfg_update(cfg_upd), .smp_data(smp_data), .smp_valid(smp_valid),
        .smp_ready(smp_ready), .irq_o(irq)
    );

    // Reference model state
    bit         m_en, m_irq_en, m_unf, m_ovf, m_irq, m_ack, m_cfg;
    bit [1:0]   m_wave;
    bit [31:0]  m_tun;
    bit [11:0]  m_amp;
    logic [11:0] m_q[$];
    logic [31:0] exp_rd[$];
    logic [11:0] exp_smp[$];
    logic [11:0] act_smp[$];

    int  n_chk = 0, n_pass = 0;
    bit  started = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endfunction

    // Applies the effect of the inputs present at a rising edge to the model.
    function automatic void model_update();
        bit         pop, req, hit, wr, set_unf, set_ovf, clr_unf, clr_ovf, flush, push, cfg, irq_next;
        int         off, lvl;
        logic [31:0] rdata;
        if (rst) begin
            m_en = 0; m_irq_en = 0; m_unf = 0; m_ovf = 0; m_irq = 0; m_ack = 0; m_cfg = 0;
            m_wave = 0; m_tun = 0; m_amp = 0;
            m_q.delete();
            return;
        end
        lvl      = m_q.size();
        pop      = smp_ready && lvl > 0;
        req      = cyc && stb && !m_ack;
        hit      = adr[31:8] == BASE[31:8];
        off      = int'(adr[7:2]);
        wr       = req && we && hit;
        set_unf  = smp_ready && lvl == 0 && m_en && m_wave == 2'd3;
        irq_next = m_irq_en && (m_unf || m_ovf);
        rdata    = 32'h0;
        if (req && !we && hit) begin
            case (off)
                0: rdata = {27'b0, m_irq_en, 1'b0, m_wave, m_en};
                1: rdata = m_tun;
                2: rdata = {20'b0, m_amp};
                3: rdata = {16'b0, 8'(lvl), 4'b0, m_ovf, m_unf, lvl == DEPTH, lvl == 0};
                5: rdata = 32'h5347_0001;
                default: rdata = 32'h0;
            endcase
        end
        flush = 0; push = 0; clr_unf = 0; clr_ovf = 0; cfg = 0; set_ovf = 0;
        if (wr) begin
            case (off)
                0: begin
                    cfg = 1;
                    if (sel[0]) begin
                        m_en = dat[0]; m_wave = dat[2:1]; m_irq_en = dat[4]; flush = dat[3];
                    end
                end
                1: begin
                    cfg = 1;
                    for (int b = 0; b < 4; b++) if (sel[b]) m_tun[b*8 +: 8] = dat[b*8 +: 8];
                end
                2: begin
                    cfg = 1;
                    if (sel[0]) m_amp[7:0]  = dat[7:0];
                    if (sel[1]) m_amp[11:8] = dat[11:8];
                end
                3: if (sel[0]) begin clr_unf = dat[2]; clr_ovf = dat[3]; end
                4: push = |sel;
                default: ;
            endcase
        end
        if (flush) m_q.delete();
        else begin
            if (pop) exp_smp.push_back(m_q.pop_front());
            if (push) begin
                if (m_q.size() < DEPTH) m_q.push_back(dat[11:0]);
                else set_ovf = 1;
            end
        end
        m_unf = (m_unf && !clr_unf) || set_unf;
        m_ovf = (m_ovf && !clr_ovf) || set_ovf;
        m_irq = irq_next;
        m_cfg = cfg;
        m_ack = req;
        if (req) exp_rd.push_back(rdata);
    endfunction

    // Monitor: compares DUT outputs with the model and drains the scoreboards.
    always @(negedge clk) begin
        if (started) begin
            chk("ack", ack, m_ack);
            if (ack) begin
                if (exp_rd.size() > 0) chk("rdata", dat_o, exp_rd.pop_front());
                else chk("spurious_ack", ack, 1'b0);
            end else begin
                chk("dat_o_idle", dat_o, 32'h0);
            end
            chk("cfg_update", cfg_upd, m_cfg);
            chk("enable", en, m_en);
            chk("wave_sel", wave, m_wave);
            chk("tuning", tun, m_tun);
            chk("amplitude", amp, m_amp);
            chk("smp_valid", smp_valid, m_q.size() != 0);
            if (m_q.size() != 0) chk("smp_head", smp_data, m_q[0]);
            chk("irq", irq, m_irq);
            while (exp_smp.size() > 0 && act_smp.size() > 0)
                chk("smp_stream", act_smp.pop_front(), exp_smp.pop_front());
            if (smp_valid && smp_ready) act_smp.push_back(smp_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic wb(input bit w, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
        cyc = 1; stb = 1; we = w; adr = a; sel = s; dat = d;
        tick();
        cyc = 0; stb = 0; we = 0;
        tick();
    endtask

    initial begin
        int op;
        logic [31:0] d;
        logic [3:0]  s;
        logic [5:0]  o;
        rst = 1;
        tick();
        started = 1;
        tick();
        rst = 0;
        tick();

        // ID read and config writes
        wb(0, BASE + 32'h14, 4'hF, 0);
        wb(1, BASE + 32'h04, 4'b0011, 32'h0123_4567);
        wb(1, BASE + 32'h00, 4'hF, 32'h7);
        chk("dir_tuning", tun, 32'h0000_4567);
        chk("dir_wave", wave, 2'd3);
        chk("dir_enable", en, 1'b1);

        // Fill, overflow, drain, underrun, irq
        for (int i = 1; i <= 16; i++) wb(1, BASE + 32'h10, 4'hF, i);
        wb(1, BASE + 32'h10, 4'hF, 32'h011);
        wb(0, BASE + 32'h0C, 4'hF, 0);
        chk("dir_head", smp_data, 12'h001);
        smp_ready = 1;
        for (int i = 0; i < 19; i++) tick();
        wb(1, BASE + 32'h00, 4'h1, 32'h17);
        chk("dir_irq_set", irq, 1'b1);
        smp_ready = 0;
        wb(1, BASE + 32'h0C, 4'h1, 32'hC);
        chk("dir_irq_clr", irq, 1'b0);

        // Push into a full FIFO while the head is consumed
        for (int i = 0; i < 16; i++) wb(1, BASE + 32'h10, 4'hF, 32'h100 + i);
        smp_ready = 1;
        cyc = 1; stb = 1; we = 1; adr = BASE + 32'h10; sel = 4'hF; dat = 32'h2AA;
        tick();
        smp_ready = 0; cyc = 0; stb = 0; we = 0;
        tick();
        wb(0, BASE + 32'h0C, 4'hF, 0);
        wb(1, BASE + 32'h00, 4'h1, 32'h0F);

        // Out-of-window and unmapped accesses; stb held to see ack spacing
        wb(1, BASE + 32'h204, 4'hF, 32'hFFFF_FFFF);
        wb(0, BASE + 32'h200, 4'hF, 0);
        wb(1, BASE + 32'h18, 4'hF, 32'hFFFF_FFFF);
        wb(0, BASE + 32'h18, 4'hF, 0);
        chk("dir_oob_tuning", tun, 32'h0000_4567);
        cyc = 1; stb = 1; we = 0; adr = BASE + 32'h04; sel = 4'hF;
        tick(); tick(); tick();
        cyc = 0; stb = 0;
        tick();

        // Reset in the middle of an access
        cyc = 1; stb = 1; we = 1; adr = BASE + 32'h04; sel = 4'hF; dat = 32'hDEAD_BEEF;
        rst = 1;
        tick();
        rst = 0; cyc = 0; stb = 0; we = 0;
        tick();
        chk("dir_rst_tuning", tun, 32'h0);
        chk("dir_rst_enable", en, 1'b0);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            op = int'($urandom_range(0, 9));
            smp_ready = 1'($urandom);
            d = $urandom;
            s = 4'($urandom_range(1, 15));
            o = 6'($urandom_range(0, 7));
            case (op)
                0: begin
                    if (d[3]) smp_ready = 0;
                    d[2:1] = ($urandom_range(0, 3) == 0) ? d[2:1] : 2'd3;
                    wb(1, BASE, s, d);
                end
                1: wb(1, BASE + 32'h04, s, d);
                2: wb(1, BASE + 32'h08, s, d);
                3: wb(1, BASE + 32'h0C, 4'($urandom), d);
                4, 5, 6: wb(1, BASE + 32'h10, 4'($urandom), d);
                7: wb(0, BASE + {24'h0, o, 2'b00}, 4'hF, 0);
                8: wb(1'($urandom), 32'h3000_0100 + {24'h0, o, 2'b00}, s, d);
                default: tick();
            endcase
        end

        smp_ready = 0; cyc = 0; stb = 0;
        repeat (3) tick();
        chk("pending_acks", exp_rd.size(), 0);
        chk("pending_samples", exp_smp.size() + act_smp.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
